mont_square_sequencer: RTL
==========================

# mont_square_sequencer

Control sequencer that drives `multi_mode_multiplier` to perform repeated redundant-form Montgomery squarings, A ← A²·R⁻¹ mod M, for a programmed iteration count. It sits directly upstream of the multiplier. For each iteration it issues three multiplier operations in order: square, multiply-lower by M′, and multiply-upper by M with the add term. It captures each registered multiplier result and returns the final A over a valid/ready handshake.

## Interface
- `NUM_ELEMENTS`, 33: words per operand; the multiplier result is 2·NUM_ELEMENTS words.
- `DSP_BIT_LEN`, 17: redundant word width.
- `WORD_LEN`, 16: canonical word width; R = 2^(WORD_LEN·NUM_ELEMENTS).
- `MUL_LAT`, 1: multiplier output latency in cycles. Must be ≥1.
- `ITER_W`, 32: iteration counter width.
- `i_clk`  in  1: clock; all state updates on the rising edge.
- `i_rst`  in  1: reset, asynchronous, active-high.
- `i_start`  in  1: start request; accepted when `i_start & o_ready` at an edge.
- `i_sq_in`  in  [DSP_BIT_LEN-1:0] x NUM_ELEMENTS: initial A, sampled on accept.
- `i_modulus`  in  [DSP_BIT_LEN-1:0] x NUM_ELEMENTS: M, sampled on accept.
- `i_mod_inv`  in  [DSP_BIT_LEN-1:0] x NUM_ELEMENTS: M′ = −M⁻¹ mod R, sampled on accept.
- `i_num_iter`  in  ITER_W: number of squarings, sampled on accept.
- `o_ready`  out  1: idle, can accept a start.
- `o_mul_ctl`  out  3: one-hot multiplier mode. 001 = square, 010 = multiply lower, 100 = multiply upper, 000 = idle.
- `o_mul_a`, `o_mul_b`, `o_mul_add`  out  [DSP_BIT_LEN-1:0] x NUM_ELEMENTS: multiplier operands and add term.
- `i_mul_dat`  in  [DSP_BIT_LEN-1:0] x 2·NUM_ELEMENTS: multiplier registered output.
- `o_valid`  out  1: result available.
- `o_dat`  out  [DSP_BIT_LEN-1:0] x NUM_ELEMENTS: final A; stable while `o_valid` is high.
- `i_ready`  in  1: result consumer ready.

## Operation
- **States:** IDLE, SQ, LO, HI, DONE. `o_ready` = (state == IDLE). `o_valid` = (state == DONE).
- **IDLE:**
  - On accept, register A, M, M′ and the iteration count.
  - If the count is 0, go to DONE; otherwise go to SQ.
  - `i_start` in any other state is ignored.
- **Phase counter:** `cnt` runs 0..MUL_LAT within each of SQ, LO and HI.
  - `o_mul_ctl` and the operands are held constant for the whole phase.
  - At `cnt == MUL_LAT`, capture `i_mul_dat` and advance to the next state; `cnt` returns to 0.
- **SQ:** ctl = 001, a = b = A, add = 0. Capture T[0..2N−1].
- **LO:** ctl = 010, a = T[0..N−1], b = M′, add = 0. Capture Q = words 0..N−1.
- **HI:** ctl = 100, a = Q, b = M, add[i] = T[N+i]. Capture the new A = `i_mul_dat` words N..2N−1, then decrement the remaining count.
  - If the remaining count becomes 0, go to DONE; otherwise go to SQ.
- **DONE:** `o_dat` = A. When `i_ready` is high at an edge, go to IDLE.
- **Outside SQ/LO/HI:** `o_mul_ctl` = 000 and the operands are 0.
- **Arithmetic:** redundant words pass through unchanged; the block does no arithmetic on data. The iteration counter wraps never: it stops at 0.

## Timing
- **Latency:** the accept edge to the first cycle with `o_valid` high spans 3·(MUL_LAT+1)·i_num_iter + 1 cycles.
  - With MUL_LAT = 1, one iteration takes 6 cycles.
- `o_mul_ctl` changes only on phase boundaries and is never multi-hot.
- **Backpressure:** DONE is held indefinitely while `i_ready` is low, with `o_dat` stable. An `i_ready` held high during DONE costs one cycle.
- **Reset values:**
  - state = IDLE, `cnt` = 0.
  - `o_ready` = 1, `o_valid` = 0, `o_mul_ctl` = 000.
  - All operand and data registers = 0.
- **Reset mid-operation:** reset in any state aborts immediately, with no pending output.
- **Simultaneous `i_start` and `i_ready` in DONE:** the start is ignored, because `o_ready` is 0. The next start is accepted in IDLE one cycle later.

## Configuration
- `MONT_SEQ_CYCLE_CNT_EN` defined:
  - Adds output `o_cycle_cnt` [31:0]. It clears on accept, increments every cycle in SQ/LO/HI, and holds in DONE and IDLE. Its reset value is 0.
- `MONT_SEQ_CYCLE_CNT_EN` undefined:
  - The port and the counter are absent; behaviour is otherwise identical.

## Test plan
- **Zero iterations:** `i_num_iter` = 0, A = 5 → `o_valid` high 1 cycle after accept, `o_dat` = 5, `o_mul_ctl` stays 000.
- **Single iteration:** NUM_ELEMENTS = 4, MUL_LAT = 1, `i_num_iter` = 1, with a behavioural bench multiplier.
  - `o_mul_ctl` sequence is 001, 001, 010, 010, 100, 100.
  - `o_valid` rises at cycle 7; `o_dat` ≡ A²·R⁻¹ mod M.
- **Backpressure:** hold `i_ready` low for 10 cycles in DONE, pulsing `i_start` → `o_valid` and `o_dat` unchanged, start ignored, IDLE one cycle after `i_ready` rises.
- **Reset mid-operation:** assert `i_rst` during HI with `cnt` = 0 → immediately `o_mul_ctl` = 000, `o_valid` = 0, `o_ready` = 1. A fresh run afterwards produces the correct result.
- **Long run:** MUL_LAT = 3, `i_num_iter` = 1000 → `o_valid` at cycle 12001. The result matches the bench model of 1000 modular squarings; with `MONT_SEQ_CYCLE_CNT_EN`, `o_cycle_cnt` = 12000.

Source files
------------

// File: rtl/mont_square_sequencer.sv
// mont_square_sequencer
// Drives a multi-mode multiplier through repeated Montgomery squarings,
// A <- A^2 * R^-1 mod M, keeping all data in redundant word form.
// Each iteration runs three phases: square, multiply-lower by M', and
// multiply-upper by M with the upper half of the square as the add term.
// Each phase is MUL_LAT+1 cycles long.
// Optional feature: define MONT_SEQ_CYCLE_CNT_EN to add o_cycle_cnt. That
// output counts the busy cycles of the most recent run.
module mont_square_sequencer #(
  parameter int NUM_ELEMENTS = 33,
  parameter int DSP_BIT_LEN  = 17,
  parameter int WORD_LEN     = 16,
  parameter int MUL_LAT      = 1,
  parameter int ITER_W       = 32
) (
  input  logic                                        i_clk,
  input  logic                                        i_rst,
  input  logic                                        i_start,
  input  logic [NUM_ELEMENTS-1:0][DSP_BIT_LEN-1:0]    i_sq_in,
  input  logic [NUM_ELEMENTS-1:0][DSP_BIT_LEN-1:0]    i_modulus,
  input  logic [NUM_ELEMENTS-1:0][DSP_BIT_LEN-1:0]    i_mod_inv,
  input  logic [ITER_W-1:0]                           i_num_iter,
  output logic                                        o_ready,
  output logic [2:0]                                  o_mul_ctl,
  output logic [NUM_ELEMENTS-1:0][DSP_BIT_LEN-1:0]    o_mul_a,
  output logic [NUM_ELEMENTS-1:0][DSP_BIT_LEN-1:0]    o_mul_b,
  output logic [NUM_ELEMENTS-1:0][DSP_BIT_LEN-1:0]    o_mul_add,
  input  logic [2*NUM_ELEMENTS-1:0][DSP_BIT_LEN-1:0]  i_mul_dat,
  output logic                                        o_valid,
  output logic [NUM_ELEMENTS-1:0][DSP_BIT_LEN-1:0]    o_dat,
  input  logic                                        i_ready
`ifdef MONT_SEQ_CYCLE_CNT_EN
  ,
  output logic [31:0]                                 o_cycle_cnt
`endif
);

  localparam int CNT_W = (MUL_LAT < 1) ? 1 : $clog2(MUL_LAT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MUL_LAT);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_SQ   = 3'd1;
  localparam logic [2:0] S_LO   = 3'd2;
  localparam logic [2:0] S_HI   = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;

  localparam logic [2:0] CTL_IDLE = 3'b000;
  localparam logic [2:0] CTL_SQ   = 3'b001;
  localparam logic [2:0] CTL_LO   = 3'b010;
  localparam logic [2:0] CTL_HI   = 3'b100;

  typedef logic [NUM_ELEMENTS-1:0][DSP_BIT_LEN-1:0]   vec_t;
  typedef logic [2*NUM_ELEMENTS-1:0][DSP_BIT_LEN-1:0] wide_t;

  // Reject configurations that cannot work: the multiplier needs at least
  // one register stage, and redundant words must be wider than canonical.
  if ((MUL_LAT < 1) || (WORD_LEN >= DSP_BIT_LEN)) begin : g_param_check
    $error("mont_square_sequencer: needs MUL_LAT >= 1 and WORD_LEN < DSP_BIT_LEN");
  end

  logic [2:0]        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ITER_W-1:0] iter_q, iter_d;
  vec_t              a_q, a_d;        // running A
  vec_t              m_q, m_d;        // modulus M
  vec_t              minv_q, minv_d;  // M' = -M^-1 mod R
  vec_t              q_q, q_d;        // Montgomery quotient Q
  wide_t             t_q, t_d;        // full square T

  logic accept;
  logic busy;
  logic phase_last;

  assign accept     = (state_q == S_IDLE) && i_start;
  assign busy       = (state_q == S_SQ) || (state_q == S_LO) || (state_q == S_HI);
  assign phase_last = (cnt_q == CNT_LAST);

  // Next-state logic: sequence the phases and capture multiplier results.
  always_comb begin
    // NOTE: every signal gets a default first, so no path leaves it
    // unassigned and no latch is inferred.
    state_d = state_q;
    iter_d  = iter_q;
    a_d     = a_q;
    m_d     = m_q;
    minv_d  = minv_q;
    q_d     = q_q;
    t_d     = t_q;
    case (state_q)
      S_IDLE: begin
        if (i_start) begin
          a_d     = i_sq_in;
          m_d     = i_modulus;
          minv_d  = i_mod_inv;
          iter_d  = i_num_iter;
          state_d = (i_num_iter == '0) ? S_DONE : S_SQ;
        end
      end
      S_SQ: begin
        if (phase_last) begin
          t_d     = i_mul_dat;
          state_d = S_LO;
        end
      end
      S_LO: begin
        if (phase_last) begin
          q_d     = i_mul_dat[NUM_ELEMENTS-1:0];
          state_d = S_HI;
        end
      end
      S_HI: begin
        if (phase_last) begin
          a_d     = i_mul_dat[2*NUM_ELEMENTS-1:NUM_ELEMENTS];
          // The remaining count saturates at zero instead of wrapping.
          iter_d  = (iter_q != '0) ? iter_q - ITER_W'(1) : '0;
          state_d = (iter_q <= ITER_W'(1)) ? S_DONE : S_SQ;
        end
      end
      S_DONE: begin
        if (i_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Phase counter: it runs 0..MUL_LAT inside a busy phase and is 0 otherwise.
  always_comb begin
    cnt_d = '0;
    if (busy && !phase_last) cnt_d = cnt_q + CNT_W'(1);
  end

  // State and data registers.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      iter_q  <= '0;
      // NOTE: these are small flop banks, not RAMs. Resetting them costs
      // little, and the operand outputs are then defined straight out of
      // reset.
      a_q     <= '0;
      m_q     <= '0;
      minv_q  <= '0;
      q_q     <= '0;
      t_q     <= '0;
    end else begin
      // NOTE: non-blocking assignments, so every flop samples the values
      // from before the edge, whatever the statement order.
      state_q <= state_d;
      cnt_q   <= cnt_d;
      iter_q  <= iter_d;
      a_q     <= a_d;
      m_q     <= m_d;
      minv_q  <= minv_d;
      q_q     <= q_d;
      t_q     <= t_d;
    end
  end

  // Multiplier command: derived only from registered state, so it holds
  // steady for a whole phase and is zero outside SQ/LO/HI.
  always_comb begin
    o_mul_ctl = CTL_IDLE;
    o_mul_a   = '0;
    o_mul_b   = '0;
    o_mul_add = '0;
    case (state_q)
      S_SQ: begin
        o_mul_ctl = CTL_SQ;
        o_mul_a   = a_q;
        o_mul_b   = a_q;
      end
      S_LO: begin
        o_mul_ctl = CTL_LO;
        o_mul_a   = t_q[NUM_ELEMENTS-1:0];
        o_mul_b   = minv_q;
      end
      S_HI: begin
        o_mul_ctl = CTL_HI;
        o_mul_a   = q_q;
        o_mul_b   = m_q;
        o_mul_add = t_q[2*NUM_ELEMENTS-1:NUM_ELEMENTS];
      end
      default: ;
    endcase
  end

  assign o_ready = (state_q == S_IDLE);
  assign o_valid = (state_q == S_DONE);
  assign o_dat   = a_q;

`ifdef MONT_SEQ_CYCLE_CNT_EN
  logic [31:0] cyc_q, cyc_d;

  // Busy-cycle counter: it clears on accept, counts SQ/LO/HI cycles and
  // holds in IDLE and DONE.
  always_comb begin
    cyc_d = cyc_q;
    if (accept)    cyc_d = '0;
    else if (busy) cyc_d = cyc_q + 32'd1;
  end

  // Busy-cycle counter register.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) cyc_q <= '0;
    else       cyc_q <= cyc_d;
  end

  assign o_cycle_cnt = cyc_q;
`else
  logic unused_accept;
  assign unused_accept = accept;
`endif

endmodule
